dmem_responder: RTL and testbench

- Data-memory slave that answers the core's MEM-stage load/store requests.
- Accepts one request at a time over a valid/ready handshake.
- Models a fixed access latency with a counter-driven state machine.
- Performs byte/half/word reads with sign or zero extension, byte-lane writes, and alignment and range checking.
- Sits opposite the pipeline's EX/MEM register and feeds the MEM/WB register.

---
 rtl/dmem_responder.sv | 213 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave for the MEM stage.
// Takes one load/store at a time over valid/ready, waits a fixed number
// of cycles, then returns a single-cycle response. Stores commit on the
// edge that enters RESP; loads are extended to 32 bits as funct3 asks.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_valid,
    output logic        mem_req_ready,
    input  logic [31:0] mem_req_addr,
    input  logic        mem_req_write,
    input  logic [2:0]  mem_req_type,
    input  logic [31:0] mem_req_wdata,
    output logic        mem_resp_valid,
    output logic [31:0] mem_resp_data,
    output logic        mem_resp_error
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_data;
    logic        r_resp_error;

    logic [31:0] r_addr;
    logic        r_write;
    logic [2:0]  r_type;
    logic [31:0] r_wdata;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_commit;
    logic [31:0]   w_addr;
    logic          w_write;
    logic [2:0]    w_type;
    logic [31:0]   w_wdata;
    logic [AW-1:0] w_idx;
    logic          w_misalign;
    logic          w_illegal;
    logic          w_oor;
    logic          w_error;
    logic [31:0]   w_rword;
    logic [31:0]   w_resp_data;
    logic [3:0]    w_be;
    logic [31:0]   w_wlanes;

    // Select the byte/halfword of a word and sign- or zero-extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  ty);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (ty)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    assign w_accept = (r_state == IDLE) && r_ready && mem_req_valid;

    // With LATENCY = 1 the response is produced on the accept edge itself,
    // so the operand view switches to the live request inputs while IDLE.
    assign w_enter_resp = ((LATENCY == 1) && w_accept) ||
                          ((r_state == BUSY) && (r_cnt == 4'd1));

    assign w_addr  = (r_state == IDLE) ? mem_req_addr  : r_addr;
    assign w_write = (r_state == IDLE) ? mem_req_write : r_write;
    assign w_type  = (r_state == IDLE) ? mem_req_type  : r_type;
    assign w_wdata = (r_state == IDLE) ? mem_req_wdata : r_wdata;

    assign w_idx = w_addr[AW+1:2];

    // Alignment, type legality and range checks on the operand view.
    always_comb begin
        w_misalign = 1'b0;
        w_illegal  = 1'b0;
        case (w_type)
            3'b000, 3'b100: w_misalign = 1'b0;
            3'b001, 3'b101: w_misalign = w_addr[0];
            3'b010:         w_misalign = (w_addr[1:0] != 2'b00);
            default:        w_illegal  = 1'b1;
        endcase
    end

    assign w_oor   = ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign w_error = w_misalign | w_illegal | w_oor;

    assign w_rword     = r_mem[w_idx];
    assign w_resp_data = (w_write || w_error) ? 32'h0
                                              : load_extend(w_rword, w_addr[1:0], w_type);

    // Byte enables and lane-replicated store data; BU/HU store like B/H.
    always_comb begin
        w_be     = 4'b1111;
        w_wlanes = w_wdata;
        case (w_type[1:0])
            2'b00: begin
                w_be     = 4'b0001 << w_addr[1:0];
                w_wlanes = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be     = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{w_wdata[15:0]}};
            end
            default: begin
                w_be     = 4'b1111;
                w_wlanes = w_wdata;
            end
        endcase
    end

    // A reset on the RESP-entry edge suppresses the commit.
    assign w_commit = w_enter_resp && !rst && w_write && !w_error;

    // Control FSM: state, latency counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_ready      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'h0;
            r_resp_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_resp_valid <= 1'b0;
                    r_resp_data  <= 32'h0;
                    r_resp_error <= 1'b0;
                    r_ready      <= 1'b1;
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            r_state      <= RESP;
                            r_cnt        <= 4'd0;
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= w_resp_data;
                            r_resp_error <= w_error;
                        end else begin
                            r_state <= BUSY;
                            r_cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    r_ready <= 1'b0;
                    if (r_cnt == 4'd1) begin
                        r_state      <= RESP;
                        r_cnt        <= 4'd0;
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= w_resp_data;
                        r_resp_error <= w_error;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state      <= IDLE;
                    r_ready      <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_data  <= 32'h0;
                    r_resp_error <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Capture the request on accept; held stable through BUSY.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= mem_req_addr;
            r_write <= mem_req_write;
            r_type  <= mem_req_type;
            r_wdata <= mem_req_wdata;
        end
    end

    // Byte-lane store into the word array; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int l = 0; l < 4; l++) begin
                if (w_be[l]) begin
                    r_mem[w_idx][8*l +: 8] <= w_wlanes[8*l +: 8];
                end
            end
        end
    end

    assign mem_req_ready  = r_ready;
    assign mem_resp_valid = r_resp_valid;
    assign mem_resp_data  = r_resp_data;
    assign mem_resp_error = r_resp_error;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2 and one at
// LATENCY=3 share the request bus, each with its own valid line.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid2 = 1'b0;
    logic        valid3 = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        write = 1'b0;
    logic [2:0]  rtype = 3'b010;
    logic [31:0] wdata = 32'h0;

    logic        ready2, rv2, re2;
    logic [31:0] rd2;
    logic        ready3, rv3, re3;
    logic [31:0] rd3;

    int n_chk = 0;
    int n_err = 0;
    bit sel3  = 1'b0;

    logic        w_rdy, w_vld, w_er;
    logic [31:0] w_rd;
    assign w_rdy = sel3 ? ready3 : ready2;
    assign w_vld = sel3 ? rv3    : rv2;
    assign w_er  = sel3 ? re3    : re2;
    assign w_rd  = sel3 ? rd3    : rd2;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .mem_req_valid(valid2), .mem_req_ready(ready2),
        .mem_req_addr(addr), .mem_req_write(write),
        .mem_req_type(rtype), .mem_req_wdata(wdata),
        .mem_resp_valid(rv2), .mem_resp_data(rd2), .mem_resp_error(re2)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .mem_req_valid(valid3), .mem_req_ready(ready3),
        .mem_req_addr(addr), .mem_req_write(write),
        .mem_req_type(rtype), .mem_req_wdata(wdata),
        .mem_resp_valid(rv3), .mem_resp_data(rd3), .mem_resp_error(re3)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Issue one request to the selected instance and wait for its response.
    task automatic xact(input logic wr, input logic [2:0] ty, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rdat,
                        output logic rerr, output int lat);
        int g;
        @(negedge clk);
        addr = a; write = wr; rtype = ty; wdata = wd;
        if (sel3) valid3 = 1'b1; else valid2 = 1'b1;
        g = 0;
        while (!w_rdy && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g == 20) chk("ready_timeout", {31'b0, w_rdy}, 32'd1);
        @(posedge clk);
        #1;
        valid2 = 1'b0;
        valid3 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!w_vld && lat < 20);
        if (lat == 20) chk("resp_timeout", {31'b0, w_vld}, 32'd1);
        rdat = w_rd;
        rerr = w_er;
    endtask

    task automatic run(input string tag, input logic wr, input logic [2:0] ty,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e);
        logic [31:0] d;
        logic        e;
        int          lat;
        xact(wr, ty, a, wd, d, e, lat);
        chk({tag, "_data"}, d, exp_d);
        chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_e});
        chk({tag, "_lat"}, lat, sel3 ? 32'd3 : 32'd2);
    endtask

    initial begin
        logic [7:0] exp_rdy;
        logic [7:0] exp_vld;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready2", {31'b0, ready2}, 32'd0);
        chk("rst_ready3", {31'b0, ready3}, 32'd0);
        chk("rst_valid", {31'b0, rv2}, 32'd0);
        chk("rst_data", rd2, 32'h0);
        chk("rst_err", {31'b0, re2}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, ready2}, 32'd1);

        // Word store/load
        sel3 = 1'b0;
        run("st_w10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        run("ld_w10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte lanes
        run("st_b13", 1'b1, 3'b000, 32'h13, 32'h0000007F, 32'h0, 1'b0);
        run("ld_b13", 1'b0, 3'b000, 32'h13, 32'h0, 32'h0000007F, 1'b0);
        run("ld_w10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'h7FADBEEF, 1'b0);
        run("ld_b12", 1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFFFFAD, 1'b0);
        run("ld_bu12", 1'b0, 3'b100, 32'h12, 32'h0, 32'h000000AD, 1'b0);

        // Halfword extension
        run("st_h22", 1'b1, 3'b001, 32'h22, 32'h00008001, 32'h0, 1'b0);
        run("ld_h22", 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0);
        run("ld_hu22", 1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001, 1'b0);

        // Errors
        run("st_w12_mis", 1'b1, 3'b010, 32'h12, 32'hFFFFFFFF, 32'h0, 1'b1);
        run("ld_h21_mis", 1'b0, 3'b001, 32'h21, 32'h0, 32'h0, 1'b1);
        run("ty011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
        run("ld_oor", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        chk("idle_err_clear", {31'b0, re2}, 32'd0);
        chk("idle_data_clear", rd2, 32'h0);
        run("ld_w10_after_err", 1'b0, 3'b010, 32'h10, 32'h0, 32'h7FADBEEF, 1'b0);

        // Handshake on the LATENCY=3 instance with valid held high
        sel3 = 1'b1;
        @(negedge clk);
        addr = 32'h40; write = 1'b1; rtype = 3'b010; wdata = 32'h11111111;
        valid3 = 1'b1;
        exp_rdy = 8'b0001_0001;
        exp_vld = 8'b1000_1000;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("hs_ready%0d", i), {31'b0, ready3}, {31'b0, exp_rdy[i]});
            chk($sformatf("hs_valid%0d", i), {31'b0, rv3}, {31'b0, exp_vld[i]});
            if (i == 3) chk("hs_store_data", rd3, 32'h0);
            if (i == 1) begin
                addr = 32'h44;
                wdata = 32'h22222222;
            end
            @(negedge clk);
        end
        valid3 = 1'b0;
        run("ld_w40", 1'b0, 3'b010, 32'h40, 32'h0, 32'h11111111, 1'b0);
        run("ld_w44", 1'b0, 3'b010, 32'h44, 32'h0, 32'h22222222, 1'b0);

        // Reset abort, with reset landing on the RESP-entry edge
        sel3 = 1'b0;
        run("st_w30", 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0);
        @(negedge clk);
        addr = 32'h30; write = 1'b1; rtype = 3'b010; wdata = 32'h12345678;
        valid2 = 1'b1;
        @(posedge clk);
        #1;
        valid2 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready_in_rst", {31'b0, ready2}, 32'd0);
        chk("abort_no_resp", {31'b0, rv2}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", {31'b0, ready2}, 32'd1);
        chk("abort_no_resp2", {31'b0, rv2}, 32'd0);
        run("ld_w30", 1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
